// File: rtl/tick_stopwatch.sv
// tick_stopwatch: MM:SS BCD stopwatch counting rising edges of a gen_tick square wave
// Ports: clk, reset (sync, active-high), tick_in (square wave), start_stop/clear/lap (1-cycle pulses);
//        digits {min_tens,min_ones,sec_tens,sec_ones}, running, lap_active, wrap (1-cycle rollover pulse).
module tick_stopwatch #(
  parameter int TICKS_PER_INC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t      state_q, state_d;
  logic        tick_prev_q;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc, digits_q, digits_d;
  logic        running_q, running_d, lap_q, lap_d, wrap_q, wrap_d;
  logic        rise, cnt_en, inc, c0, c1, c2, c3;
  always_comb begin
    rise = tick_in & ~tick_prev_q;
    // only the pre-transition state decides whether a rise counts
    cnt_en = rise & (state_q == RUN);
    inc = cnt_en & (presc_q == 8'(TICKS_PER_INC - 1));
    c0 = cnt_q[3:0] == 4'd9;
    c1 = c0 & (cnt_q[7:4] == 4'd5);
    c2 = c1 & (cnt_q[11:8] == 4'd9);
    c3 = c2 & (cnt_q[15:12] == 4'd5);
    cnt_inc = {c3 ? 4'd0 : c2 ? cnt_q[15:12] + 4'd1 : cnt_q[15:12],
               c2 ? 4'd0 : c1 ? cnt_q[11:8] + 4'd1 : cnt_q[11:8],
               c1 ? 4'd0 : c0 ? cnt_q[7:4] + 4'd1 : cnt_q[7:4],
               c0 ? 4'd0 : cnt_q[3:0] + 4'd1};
    state_d = clear ? IDLE : !start_stop ? state_q : state_q == RUN ? PAUSE : RUN;
    presc_d = clear ? 8'd0 : !cnt_en ? presc_q : inc ? 8'd0 : presc_q + 8'd1;
    cnt_d = clear ? 16'd0 : inc ? cnt_inc : cnt_q;
    lap_d = clear ? 1'b0 : (lap && state_q != IDLE) ? ~lap_q : lap_q;
    // entering freeze captures the live count; staying frozen holds the display
    digits_d = !lap_d ? cnt_d : lap_q ? digits_q : cnt_q;
    running_d = state_d == RUN;
    wrap_d = ~clear & inc & c3;
  end
  always_ff @(posedge clk) begin
    tick_prev_q <= tick_in;
    if (reset) begin
      state_q <= IDLE;
      presc_q <= 8'd0;
      cnt_q <= 16'd0;
      digits_q <= 16'd0;
      running_q <= 1'b0;
      lap_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q <= cnt_d;
      digits_q <= digits_d;
      running_q <= running_d;
      lap_q <= lap_d;
      wrap_q <= wrap_d;
    end
  end
  assign digits = digits_q;
  assign running = running_q;
  assign lap_active = lap_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_tick_stopwatch.sv
// tb_tick_stopwatch: scoreboard bench for tick_stopwatch (TICKS_PER_INC=1 and 2 instances)
module tb_tick_stopwatch;
  logic clk = 0, reset = 1, tick_in = 1, start_stop = 0, clear = 0, lap = 0;
  logic [15:0] dig0, dig1;
  logic run0, run1, la0, la1, wr0, wr1;
  typedef struct {
    bit          sel;
    string       name;
    logic [15:0] dig;
    logic        run, la, wr;
  } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;
  tick_stopwatch #(.TICKS_PER_INC(1)) u0 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digits(dig0), .running(run0), .lap_active(la0), .wrap(wr0));
  tick_stopwatch #(.TICKS_PER_INC(2)) u1 (
    .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop), .clear(clear), .lap(lap),
    .digits(dig1), .running(run1), .lap_active(la1), .wrap(wr1));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [15:0] d;
      logic r, l, w;
      e = sb.pop_front();
      d = e.sel ? dig1 : dig0;
      r = e.sel ? run1 : run0;
      l = e.sel ? la1 : la0;
      w = e.sel ? wr1 : wr0;
      checks++;
      if (d === e.dig && r === e.run && l === e.la && w === e.wr) passed++;
      else $display("FAIL %s: got digits=%h running=%b lap_active=%b wrap=%b, want digits=%h running=%b lap_active=%b wrap=%b",
                    e.name, d, r, l, w, e.dig, e.run, e.la, e.wr);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input bit sel, input string name, input logic [15:0] dig, input logic run, la, wr);
    exp_t e;
    e.sel = sel; e.name = name; e.dig = dig; e.run = run; e.la = la; e.wr = wr;
    sb.push_back(e);
  endtask
  task automatic rises(input int n);
    repeat (n) begin
      tick_in = 1; step(); step();
      tick_in = 0; step(); step();
    end
  endtask
  task automatic pulse_start();
    start_stop = 1; step(); start_stop = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
  initial begin
    step(); step(); step();
    push(0, "reset_state", 16'h0000, 0, 0, 0);
    reset = 0; step(); step();
    push(0, "high_at_release", 16'h0000, 0, 0, 0);
    tick_in = 0; step(); step();
    pulse_start();
    push(0, "start", 16'h0000, 1, 0, 0);
    rises(5);
    push(0, "five_rises", 16'h0005, 1, 0, 0);
    rises(55);
    push(0, "sixty_rises", 16'h0100, 1, 0, 0);
    rises(3539);
    push(0, "at_5959", 16'h5959, 1, 0, 0);
    tick_in = 1; step();
    push(0, "wrap_pulse", 16'h0000, 1, 0, 1);
    step();
    push(0, "wrap_one_cycle", 16'h0000, 1, 0, 0);
    tick_in = 0; step(); step();
    clear = 1; step(); clear = 0;
    push(0, "clear_idle", 16'h0000, 0, 0, 0);
    lap = 1; step(); lap = 0;
    push(0, "lap_in_idle", 16'h0000, 0, 0, 0);
    pulse_start();
    rises(12);
    push(0, "at_0012", 16'h0012, 1, 0, 0);
    lap = 1; step(); lap = 0;
    push(0, "lap_freeze", 16'h0012, 1, 1, 0);
    rises(4);
    push(0, "lap_held", 16'h0012, 1, 1, 0);
    lap = 1; step(); lap = 0;
    push(0, "lap_release", 16'h0016, 1, 0, 0);
    lap = 1; step(); lap = 0;
    push(0, "lap_again", 16'h0016, 1, 1, 0);
    clear = 1; start_stop = 1; step(); clear = 0; start_stop = 0;
    push(0, "clear_and_start", 16'h0000, 0, 0, 0);
    pulse_start();
    rises(3);
    push(0, "restart_0003", 16'h0003, 1, 0, 0);
    tick_in = 1; clear = 1; step(); clear = 0;
    push(0, "clear_drops_rise", 16'h0000, 0, 0, 0);
    step(); tick_in = 0; step(); step();
    pulse_start();
    rises(2);
    push(0, "pre_reset_0002", 16'h0002, 1, 0, 0);
    reset = 1; step(); reset = 0;
    push(0, "reset_mid_run", 16'h0000, 0, 0, 0);
    step();
    pulse_start();
    rises(2);
    push(1, "div2_two_rises", 16'h0001, 1, 0, 0);
    tick_in = 1; start_stop = 1; step(); start_stop = 0;
    push(1, "div2_pause_rise", 16'h0001, 0, 0, 0);
    step(); tick_in = 0; step(); step();
    rises(4);
    push(1, "div2_paused", 16'h0001, 0, 0, 0);
    tick_in = 1; start_stop = 1; step(); start_stop = 0;
    push(1, "div2_resume", 16'h0001, 1, 0, 0);
    step(); tick_in = 0; step(); step();
    rises(1);
    push(1, "div2_0002", 16'h0002, 1, 0, 0);
    rises(1);
    push(1, "div2_still_0002", 16'h0002, 1, 0, 0);
    step(); step();
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
